pc_fetch: RTL and testbench

Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register. It owns the program counter and issues word-aligned fetch requests to instruction memory over a req/ack handshake. It presents fetched {pc, inst} pairs to IF/ID through a valid/stall interface. It also handles pipeline stalls, branch redirects from ID and exception flushes from ctrl, and absorbs in-flight responses with a one-entry skid buffer.

---
 rtl/pc_fetch_if.sv | 18 +
 rtl/pc_fetch.sv | 182 ++++++++++++++++++
 tb/tb_pc_fetch.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pc_fetch_if.sv
// Instruction-memory fetch bus between pc_fetch and instruction memory.
//   inst_req   : fetch request, held until acked
//   inst_addr  : word-aligned fetch address, stable while inst_req=1
//   inst_ack   : memory accepted request; inst_rdata valid in the same cycle
//   inst_rdata : fetched instruction
// Modports: master (fetch unit side), slave (memory side).
interface pc_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_ack;
  logic [DATA_W-1:0] inst_rdata;

  modport master (output inst_req, output inst_addr, input inst_ack, input inst_rdata);
  modport slave  (input inst_req, input inst_addr, output inst_ack, output inst_rdata);
endinterface

// File: rtl/pc_fetch.sv
// Instruction-fetch front end feeding the IF/ID register.
// Owns the PC, issues fetches over the req/ack bus, presents {pc,inst} to
// IF/ID through a registered slot, and parks one extra response in a skid
// buffer while IF/ID is stalled. Handles branch redirects and exception
// flushes, dropping any response that was in flight at redirect time.
// Ports:
//   clk, rst        : clock, async active-low reset
//   stall           : IF/ID hold; slot transfers when out_valid & ~stall
//   branch_flag/branch_target : redirect pulse from ID
//   flush/new_pc    : exception redirect from ctrl (wins over branch)
//   bus             : pc_fetch_if.master instruction-memory bus
//   out_valid/out_pc/out_inst : registered slot toward IF/ID
//   fetch_adel      : misaligned redirect target (only with PC_ALIGN_CHECK_EN)
// Build option PC_ALIGN_CHECK_EN: when defined, a misaligned redirect target
// parks the block until the next flush and raises fetch_adel; when undefined
// the low two target bits are forced to zero.
// The bus interface must be instantiated with the same ADDR_W/DATA_W.
module pc_fetch #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  pc_fetch_if.master        bus,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_inst
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic              fetch_adel
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, addr_q, addr_n, tgt_raw, tgt;
  logic [ADDR_W-1:0] skid_pc;
  logic [DATA_W-1:0] skid_inst;
  logic              skid_valid, discard, adel_q;
  logic              ack, slot_free, redir, misal, issue;

  assign bus.inst_req  = (state == REQ);
  assign bus.inst_addr = addr_q;

  assign ack       = bus.inst_req & bus.inst_ack;
  assign slot_free = ~out_valid | ~stall;
  assign tgt_raw   = flush ? new_pc : branch_target;

`ifdef PC_ALIGN_CHECK_EN
  // Parked on a bad target: only a flush can move us again.
  assign redir = flush | (branch_flag & ~adel_q);
  assign tgt   = tgt_raw;
  assign misal = |tgt_raw[1:0];
  assign fetch_adel = adel_q;
`else
  assign redir  = flush | branch_flag;
  assign tgt    = tgt_raw & ~{{(ADDR_W-2){1'b0}}, 2'b11};
  assign misal  = 1'b0;
  assign adel_q = 1'b0;
`endif

  // Next state plus "issue": load addr_q with a new fetch address.
  always_comb begin
    state_n = state;
    issue   = 1'b0;
    addr_n  = addr_q;
    unique case (state)
      IDLE: begin
        if (redir && misal) state_n = WAIT;
        else begin
          issue  = 1'b1;
          addr_n = redir ? tgt : pc;
        end
      end
      REQ: begin
        if (ack) begin
          if (redir) begin
            if (misal) state_n = WAIT;
            else begin
              issue  = 1'b1;
              addr_n = tgt;
            end
          end else if (discard) begin
            // pc already holds the redirect target captured earlier
            if (adel_q) state_n = WAIT;
            else begin
              issue  = 1'b1;
              addr_n = pc;
            end
          end else if (!slot_free) begin
            state_n = WAIT;  // response goes to skid; stop fetching
          end else begin
            issue  = 1'b1;
            addr_n = pc + ADDR_W'(4);
          end
        end
      end
      WAIT: begin
        if (redir) begin
          if (!misal) begin
            issue  = 1'b1;
            addr_n = tgt;
          end
        end else if (!adel_q && slot_free) begin
          // slot drains this edge, skid moves into it
          issue  = 1'b1;
          addr_n = pc;
        end
      end
      default: state_n = IDLE;
    endcase
    if (issue) state_n = REQ;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc         <= RESET_PC;
      addr_q     <= '0;
      discard    <= 1'b0;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_inst  <= '0;
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_inst   <= '0;
    end else begin
      if (issue) addr_q <= addr_n;

      if (redir)             pc <= tgt;
      else if (ack && !discard) pc <= pc + ADDR_W'(4);

      // An outstanding request cannot be withdrawn, so its data is dropped.
      if (ack)                        discard <= 1'b0;
      else if (redir && state == REQ) discard <= 1'b1;

      if (redir) begin
        out_valid  <= 1'b0;
        skid_valid <= 1'b0;
        if (misal) out_pc <= tgt;
      end else if (skid_valid) begin
        if (slot_free) begin
          out_valid  <= 1'b1;
          out_pc     <= skid_pc;
          out_inst   <= skid_inst;
          skid_valid <= 1'b0;
        end
      end else if (ack && !discard) begin
        if (slot_free) begin
          out_valid <= 1'b1;
          out_pc    <= addr_q;
          out_inst  <= bus.inst_rdata;
        end else begin
          skid_valid <= 1'b1;
          skid_pc    <= addr_q;
          skid_inst  <= bus.inst_rdata;
        end
      end else if (slot_free) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       adel_q <= 1'b0;
    else if (redir) adel_q <= misal;
  end
`endif

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;
  localparam logic [31:0] K = 32'h1357_0000;

  logic        clk = 1'b0;
  logic        rst, stall, branch_flag, flush, ack_on;
  logic [31:0] branch_target, new_pc;
  logic        out_valid;
  logic [31:0] out_pc, out_inst;
`ifdef PC_ALIGN_CHECK_EN
  logic        fetch_adel;
`endif
  int n_run = 0, n_fail = 0;

  always #5 clk = ~clk;

  pc_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  // zero-wait memory when ack_on; data is a fixed function of address
  assign bus.inst_ack   = ack_on & bus.inst_req;
  assign bus.inst_rdata = bus.inst_addr ^ K;

  pc_fetch #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .flush(flush), .new_pc(new_pc), .bus(bus),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst)
`ifdef PC_ALIGN_CHECK_EN
    , .fetch_adel(fetch_adel)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; branch_flag = 1'b0; flush = 1'b0; ack_on = 1'b0;
    branch_target = '0; new_pc = '0;
    tick; tick;
    chk("rst_req",   32'(bus.inst_req), 32'd0);
    chk("rst_addr",  bus.inst_addr, 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc",    out_pc, 32'd0);
    chk("rst_inst",  out_inst, 32'd0);

    // streaming, ack every cycle
    rst = 1'b1; ack_on = 1'b1;
    tick; chk("e1_req", 32'(bus.inst_req), 32'd1); chk("e1_addr", bus.inst_addr, 32'h0);
    tick; chk("e2_addr", bus.inst_addr, 32'h4); chk("e2_valid", 32'(out_valid), 32'd1);
          chk("e2_opc", out_pc, 32'h0); chk("e2_inst", out_inst, 32'h0 ^ K);
    tick; chk("e3_addr", bus.inst_addr, 32'h8); chk("e3_opc", out_pc, 32'h4);
    tick; chk("e4_addr", bus.inst_addr, 32'hC); chk("e4_opc", out_pc, 32'h8);
          chk("e4_inst", out_inst, 32'h8 ^ K);

    // stall with slot full: next response lands in skid
    stall = 1'b1;
    tick; chk("st1_req", 32'(bus.inst_req), 32'd0); chk("st1_opc", out_pc, 32'h8);
    tick; tick;
    chk("st3_req", 32'(bus.inst_req), 32'd0); chk("st3_opc", out_pc, 32'h8);
    chk("st3_valid", 32'(out_valid), 32'd1); chk("st3_inst", out_inst, 32'h8 ^ K);
    stall = 1'b0;
    tick; chk("drn_opc", out_pc, 32'hC); chk("drn_inst", out_inst, 32'hC ^ K);
          chk("drn_req", 32'(bus.inst_req), 32'd1); chk("drn_addr", bus.inst_addr, 32'h10);

    // late ack with branch during outstanding request
    ack_on = 1'b0; branch_flag = 1'b1; branch_target = 32'h100;
    tick; chk("br_addr", bus.inst_addr, 32'h10); chk("br_req", 32'(bus.inst_req), 32'd1);
          chk("br_valid", 32'(out_valid), 32'd0);
    branch_flag = 1'b0;
    tick; chk("br_hold", bus.inst_addr, 32'h10);
    ack_on = 1'b1;
    tick; chk("br_tgt", bus.inst_addr, 32'h100); chk("br_drop", 32'(out_valid), 32'd0);
    tick; chk("br_opc", out_pc, 32'h100); chk("br_ovld", 32'(out_valid), 32'd1);
          chk("br_next", bus.inst_addr, 32'h104);

    // flush + branch + stall same cycle
    flush = 1'b1; new_pc = 32'h180; branch_flag = 1'b1; branch_target = 32'h100; stall = 1'b1;
    tick; chk("fl_addr", bus.inst_addr, 32'h180); chk("fl_valid", 32'(out_valid), 32'd0);

    // PC wrap
    new_pc = 32'hFFFF_FFFC; branch_flag = 1'b0; stall = 1'b0;
    tick; chk("wr_addr", bus.inst_addr, 32'hFFFF_FFFC);
    flush = 1'b0;
    tick; chk("wr_next", bus.inst_addr, 32'h0); chk("wr_opc", out_pc, 32'hFFFF_FFFC);

    // misaligned branch target
    branch_flag = 1'b1; branch_target = 32'h102;
`ifdef PC_ALIGN_CHECK_EN
    tick; chk("al_req", 32'(bus.inst_req), 32'd0); chk("al_adel", 32'(fetch_adel), 32'd1);
          chk("al_opc", out_pc, 32'h102); chk("al_valid", 32'(out_valid), 32'd0);
    branch_target = 32'h300;
    tick; chk("al_park", 32'(bus.inst_req), 32'd0); chk("al_adel2", 32'(fetch_adel), 32'd1);
    branch_flag = 1'b0; flush = 1'b1; new_pc = 32'h200;
    tick; chk("al_req2", 32'(bus.inst_req), 32'd1); chk("al_addr", bus.inst_addr, 32'h200);
          chk("al_clr", 32'(fetch_adel), 32'd0);
    flush = 1'b0;
    tick; chk("al_opc2", out_pc, 32'h200);
`else
    tick; chk("al_addr", bus.inst_addr, 32'h100); chk("al_valid", 32'(out_valid), 32'd0);
    branch_flag = 1'b0;
    tick; chk("al_opc", out_pc, 32'h100); chk("al_next", bus.inst_addr, 32'h104);
`endif

    // reset while waiting for ack, slot held by stall
    ack_on = 1'b0; stall = 1'b1;
    tick;
    chk("mw_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mr_req",   32'(bus.inst_req), 32'd0);
    chk("mr_addr",  bus.inst_addr, 32'd0);
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_pc",    out_pc, 32'd0);
    chk("mr_inst",  out_inst, 32'd0);
`ifdef PC_ALIGN_CHECK_EN
    chk("mr_adel",  32'(fetch_adel), 32'd0);
`endif
    tick;
    rst = 1'b1; stall = 1'b0;
    tick; chk("mr_req1", 32'(bus.inst_req), 32'd1); chk("mr_addr1", bus.inst_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
